// File: rtl/bram_result_reader.sv
// Reads rows of a multi-word BRAM and streams them out one word per handshake, MSW first.
// Define BRAM_RESULT_READER_CLEAR_EN to zero each row in BRAM after it has been streamed.
module bram_result_reader #(
  parameter int CNT_BIT  = 31,
  parameter int DWIDTH_1 = 32,
  parameter int DWIDTH_2 = 128,
  parameter int AWIDTH   = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_run_i,
  input  logic [CNT_BIT-1:0]  run_count_i,
  input  logic [DWIDTH_2-1:0] q_b1_i,
  output logic [AWIDTH-1:0]   addr_b1_o,
  output logic                ce_b1_o,
  output logic                we_b1_o,
  output logic [DWIDTH_2-1:0] d_b1_o,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic [DWIDTH_1-1:0] m_data_o,
  output logic                m_last_o,
  output logic                idle_o,
  output logic                read_o,
  output logic                done_o
);

  localparam int WORDS = DWIDTH_2 / DWIDTH_1;
  localparam int WIDX  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WIDX-1:0] LAST_WORD = WIDX'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SEND,
`ifdef BRAM_RESULT_READER_CLEAR_EN
    S_CLR,
`endif
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_BIT-1:0]    r_row;
  logic [CNT_BIT-1:0]    r_count;
  logic [WIDX-1:0]       r_word;
  logic [DWIDTH_2-1:0]   r_row_data;

  logic                  w_accept;
  logic                  w_handshake;
  logic                  w_last_word;
  logic                  w_last_row;
  logic                  w_row_inc;
  logic [DWIDTH_1-1:0]   w_words [WORDS];

  assign w_accept    = (r_state == S_IDLE) && start_run_i;
  assign w_handshake = (r_state == S_SEND) && m_ready_i;
  assign w_last_word = (r_word == LAST_WORD);
  assign w_last_row  = (r_row == (r_count - CNT_BIT'(1)));

  // The row counter advances once the row is fully finished with, i.e. after its clear if any.
`ifdef BRAM_RESULT_READER_CLEAR_EN
  assign w_row_inc = (r_state == S_CLR);
`else
  assign w_row_inc = w_handshake && w_last_word;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_run_i) begin
          w_state_next = (run_count_i == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: w_state_next = S_WAIT;
      S_WAIT:  w_state_next = S_SEND;
      S_SEND: begin
        if (w_handshake && w_last_word) begin
`ifdef BRAM_RESULT_READER_CLEAR_EN
          w_state_next = S_CLR;
`else
          w_state_next = w_last_row ? S_DONE : S_FETCH;
`endif
        end
      end
`ifdef BRAM_RESULT_READER_CLEAR_EN
      S_CLR:   w_state_next = w_last_row ? S_DONE : S_FETCH;
`endif
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_row      <= '0;
      r_count    <= '0;
      r_word     <= '0;
      r_row_data <= '0;
    end else begin
      if (w_accept) begin
        r_count <= run_count_i;
        r_row   <= '0;
        r_word  <= '0;
      end else if (w_row_inc) begin
        r_row <= r_row + CNT_BIT'(1);
      end
      // BRAM data is valid in the cycle after the FETCH address.
      if (r_state == S_WAIT) begin
        r_row_data <= q_b1_i;
      end
      if (w_handshake) begin
        r_word <= r_word + WIDX'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < WORDS; i++) begin
      w_words[i] = r_row_data[DWIDTH_2 - 1 - i * DWIDTH_1 -: DWIDTH_1];
    end
  end

  always_comb begin
    idle_o    = 1'b0;
    read_o    = 1'b0;
    done_o    = 1'b0;
    m_valid_o = 1'b0;
    m_data_o  = '0;
    m_last_o  = 1'b0;
    ce_b1_o   = 1'b0;
    we_b1_o   = 1'b0;
    addr_b1_o = '0;
    case (r_state)
      S_IDLE:  idle_o = 1'b1;
      S_FETCH: begin
        read_o    = 1'b1;
        ce_b1_o   = 1'b1;
        addr_b1_o = r_row[AWIDTH-1:0];
      end
      S_WAIT:  read_o = 1'b1;
      S_SEND: begin
        read_o    = 1'b1;
        m_valid_o = 1'b1;
        m_data_o  = w_words[r_word];
        m_last_o  = w_last_word && w_last_row;
      end
`ifdef BRAM_RESULT_READER_CLEAR_EN
      S_CLR: begin
        read_o    = 1'b1;
        ce_b1_o   = 1'b1;
        we_b1_o   = 1'b1;
        addr_b1_o = r_row[AWIDTH-1:0];
      end
`endif
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  assign d_b1_o = '0;

endmodule

// File: tb/tb_bram_result_reader.sv
// Self-checking bench for bram_result_reader: directed and randomized runs against a row/word model.
module tb_bram_result_reader;

  localparam int CNT1 = 31;
  localparam int AW1  = 8;
  localparam int CNT2 = 8;
  localparam int AW2  = 2;
`ifdef BRAM_RESULT_READER_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic            start1, ready1, ce1, we1, v1, last1, idle1, read1, done1;
  logic [CNT1-1:0] cnt1;
  logic [127:0]    q1, d1;
  logic [AW1-1:0]  addr1;
  logic [31:0]     data1;

  logic            start2, ready2, ce2, we2, v2, last2, idle2, read2, done2;
  logic [CNT2-1:0] cnt2;
  logic [127:0]    q2, d2;
  logic [AW2-1:0]  addr2;
  logic [31:0]     data2;

  bram_result_reader #(.CNT_BIT(CNT1), .DWIDTH_1(32), .DWIDTH_2(128), .AWIDTH(AW1)) dut (
    .clk(clk), .reset_n(reset_n), .start_run_i(start1), .run_count_i(cnt1), .q_b1_i(q1),
    .addr_b1_o(addr1), .ce_b1_o(ce1), .we_b1_o(we1), .d_b1_o(d1),
    .m_valid_o(v1), .m_ready_i(ready1), .m_data_o(data1), .m_last_o(last1),
    .idle_o(idle1), .read_o(read1), .done_o(done1)
  );

  bram_result_reader #(.CNT_BIT(CNT2), .DWIDTH_1(32), .DWIDTH_2(128), .AWIDTH(AW2)) dut_a2 (
    .clk(clk), .reset_n(reset_n), .start_run_i(start2), .run_count_i(cnt2), .q_b1_i(q2),
    .addr_b1_o(addr2), .ce_b1_o(ce2), .we_b1_o(we2), .d_b1_o(d2),
    .m_valid_o(v2), .m_ready_i(ready2), .m_data_o(data2), .m_last_o(last2),
    .idle_o(idle2), .read_o(read2), .done_o(done2)
  );

  // BRAM models: one-cycle read latency, bench-side load port for preloading rows.
  logic [127:0] mem1 [256];
  logic [127:0] mem2 [4];
  logic         ld_en1, ld_en2;
  logic [7:0]   ld_addr;
  logic [127:0] ld_data;

  always @(posedge clk) begin
    if (ld_en1) mem1[ld_addr] <= ld_data;
    else if (ce1 && we1) mem1[addr1] <= d1;
    if (ce1 && !we1) q1 <= mem1[addr1];
  end

  always @(posedge clk) begin
    if (ld_en2) mem2[ld_addr[1:0]] <= ld_data;
    else if (ce2 && we2) mem2[addr2] <= d2;
    if (ce2 && !we2) q2 <= mem2[addr2];
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input bit sel, input int addr, input logic [127:0] data);
    ld_addr = 8'(addr);
    ld_data = data;
    if (sel) ld_en2 = 1'b1; else ld_en1 = 1'b1;
    @(posedge clk); #1;
    ld_en1 = 1'b0;
    ld_en2 = 1'b0;
  endtask

  // mode 0: always ready; 1: random ready; 2: three stall cycles on word index 2.
  task automatic run(input bit a2, input int n, input int mode, input string tag);
    int           depth = a2 ? 4 : 256;
    logic [127:0] shadow [256];
    logic [127:0] row;
    logic [31:0]  exp_w [$];
    logic         exp_l [$];
    int           exp_a [$];
    int           got_a [$];
    int           got_wa [$];
    int           idx = 0, cyc = 0, first = -1, stall = 0, done_cyc = -1;
    bit           prev_hold = 1'b0, r;
    logic [31:0]  prev_d, dat;
    logic         prev_l, v_s, lst, ce_s, we_s, dn, idl, rd;
    logic [127:0] d_s;
    int           adr;

    for (int i = 0; i < depth; i++) shadow[i] = a2 ? mem2[i] : mem1[i];
    for (int k = 0; k < n; k++) begin
      row = shadow[k % depth];
      exp_a.push_back(k % depth);
      for (int w = 0; w < 4; w++) begin
        exp_w.push_back(row[127 - 32 * w -: 32]);
        exp_l.push_back((k == n - 1) && (w == 3));
      end
      if (CLEAR_EN) shadow[k % depth] = '0;
    end

    if (a2) begin start2 = 1'b1; cnt2 = CNT2'(n); end
    else begin start1 = 1'b1; cnt1 = CNT1'(n); end
    @(posedge clk); #1;
    start1 = 1'b0;
    start2 = 1'b0;

    while (cyc < 200 + 12 * n) begin
      v_s  = a2 ? v2 : v1;
      dat  = a2 ? data2 : data1;
      lst  = a2 ? last2 : last1;
      ce_s = a2 ? ce2 : ce1;
      we_s = a2 ? we2 : we1;
      d_s  = a2 ? d2 : d1;
      dn   = a2 ? done2 : done1;
      idl  = a2 ? idle2 : idle1;
      rd   = a2 ? read2 : read1;
      adr  = a2 ? int'(addr2) : int'(addr1);

      if (ce_s && !we_s) got_a.push_back(adr);
      if (ce_s && we_s) begin
        got_wa.push_back(adr);
        check({tag, " write data"}, d_s, '0);
      end
      if (!dn) begin
        check({tag, " read_o busy"}, rd, 1'b1);
        check({tag, " idle_o busy"}, idl, 1'b0);
      end
      if (v_s && first < 0) first = cyc;
      if (prev_hold) begin
        check({tag, " held data"}, dat, prev_d);
        check({tag, " held last"}, lst, prev_l);
      end

      case (mode)
        1:       r = ($urandom_range(0, 3) != 0);
        2: begin
          if (v_s && idx == 2 && stall < 3) begin r = 1'b0; stall++; end
          else r = 1'b1;
        end
        default: r = 1'b1;
      endcase
      if (a2) ready2 = r; else ready1 = r;

      if (v_s) begin
        if (idx < exp_w.size()) begin
          check({tag, " data"}, dat, exp_w[idx]);
          check({tag, " last"}, lst, exp_l[idx]);
        end else begin
          check({tag, " extra word"}, idx, exp_w.size());
        end
        if (r) idx++;
      end
      prev_hold = v_s && !r;
      prev_d    = dat;
      prev_l    = lst;
      if (dn) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end

    check({tag, " done seen"}, done_cyc >= 0, 1'b1);
    check({tag, " word count"}, idx, exp_w.size());
    check({tag, " first valid cycle"}, first, (n > 0) ? 2 : -1);
    if (n == 0) check({tag, " done latency"}, done_cyc, 0);
    if (mode == 2) check({tag, " stall cycles"}, stall, 3);
    check({tag, " read addr count"}, got_a.size(), n);
    for (int i = 0; i < got_a.size() && i < n; i++) check({tag, " read addr"}, got_a[i], exp_a[i]);
    check({tag, " write count"}, got_wa.size(), CLEAR_EN ? n : 0);
    for (int i = 0; i < got_wa.size() && i < n; i++) check({tag, " write addr"}, got_wa[i], exp_a[i]);

    @(posedge clk); #1;
    check({tag, " done pulse width"}, a2 ? done2 : done1, 1'b0);
    check({tag, " back to idle"}, a2 ? idle2 : idle1, 1'b1);
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    start1 = 1'b0; start2 = 1'b0;
    ready1 = 1'b1; ready2 = 1'b1;
    cnt1 = '0; cnt2 = '0;
    ld_en1 = 1'b0; ld_en2 = 1'b0;
    ld_addr = '0; ld_data = '0;

    #1;
    check("reset idle_o", idle1, 1'b1);
    check("reset read_o", read1, 1'b0);
    check("reset done_o", done1, 1'b0);
    check("reset m_valid_o", v1, 1'b0);
    check("reset m_last_o", last1, 1'b0);
    check("reset m_data_o", data1, '0);
    check("reset ce_b1_o", ce1, 1'b0);
    check("reset we_b1_o", we1, 1'b0);
    check("reset addr_b1_o", addr1, '0);
    check("reset d_b1_o", d1, '0);
    check("reset idle_o a2", idle2, 1'b1);

    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    load(1'b0, 0, {32'd1, 32'd2, 32'd3, 32'd4});
    load(1'b0, 1, {32'd5, 32'd6, 32'd7, 32'd8});
    run(1'b0, 2, 0, "basic");
    check("basic row0 after", mem1[0], CLEAR_EN ? 128'h0 : {32'd1, 32'd2, 32'd3, 32'd4});
    check("basic row1 after", mem1[1], CLEAR_EN ? 128'h0 : {32'd5, 32'd6, 32'd7, 32'd8});

    load(1'b0, 0, {32'd1, 32'd2, 32'd3, 32'd4});
    run(1'b0, 1, 2, "stall");

    run(1'b0, 0, 0, "zero");

    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) load(1'b0, k, {$urandom, $urandom, $urandom, $urandom});
      run(1'b0, n, 1, "random");
    end

    load(1'b0, 0, {32'hA0, 32'hA1, 32'hA2, 32'hA3});
    load(1'b0, 1, {32'hB0, 32'hB1, 32'hB2, 32'hB3});
    ready1 = 1'b1;
    start1 = 1'b1;
    cnt1 = CNT1'(2);
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("midrst pre valid", v1, 1'b1);
    check("midrst pre data", data1, 32'hA1);
    reset_n = 1'b0;
    #1;
    check("midrst idle_o", idle1, 1'b1);
    check("midrst m_valid_o", v1, 1'b0);
    check("midrst read_o", read1, 1'b0);
    check("midrst ce_b1_o", ce1, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run(1'b0, 1, 0, "after reset");

    for (int k = 0; k < 4; k++) load(1'b1, k, {$urandom, $urandom, $urandom, $urandom});
    run(1'b1, 5, 1, "wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
